// File: rtl/waterfall_pkg.sv
// Shared constants for the waterfall datapath: ADC width, sdft sample width and midscale.
// Used by the top level, the sdft and the ADC sample conditioner.
package waterfall_pkg;

  localparam int SAMPLE_WIDTH = 12;
  localparam int DATA_W       = 8;
  localparam int MIDSCALE     = 1 << (DATA_W - 1);
  localparam int ADC_MIDSCALE = 1 << (SAMPLE_WIDTH - 1);

endpackage

// File: rtl/adc_sample_conditioner_if.sv
// ADC-side strobe and sdft-side valid/ready handshake of the ADC sample conditioner.
interface adc_sample_conditioner_if #(
  parameter int SAMPLE_WIDTH = waterfall_pkg::SAMPLE_WIDTH,
  parameter int OUT_W        = waterfall_pkg::DATA_W
);

  logic [SAMPLE_WIDTH-1:0] adc_data;
  logic                    adc_valid;
  logic [OUT_W-1:0]        out_sample;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overrun;
  logic                    clear_overrun;

  modport master (
    output adc_data, adc_valid, out_ready, clear_overrun,
    input  out_sample, out_valid, overrun
  );

  modport slave (
    input  adc_data, adc_valid, out_ready, clear_overrun,
    output out_sample, out_valid, overrun
  );

endinterface

// File: rtl/dc_tracker.sv
// First-order DC tracker: subtracts the running DC estimate from each decimated sample
// and nudges the estimate toward the sample by 2^-DC_SHIFT of the difference.
module dc_tracker #(
  parameter int SAMPLE_WIDTH = waterfall_pkg::SAMPLE_WIDTH,
  parameter int DC_SHIFT     = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [SAMPLE_WIDTH-1:0]        avg_i,
  input  logic                           s1v_i,
  output logic signed [SAMPLE_WIDTH:0]   ac_o,
  output logic                           s2v_o
);

  localparam int ACC_W = SAMPLE_WIDTH + DC_SHIFT;
  localparam logic [ACC_W-1:0] DC_RESET = ACC_W'(1) << (SAMPLE_WIDTH - 1 + DC_SHIFT);

  logic [ACC_W-1:0]               dcAcc_q, dcAcc_d;
  logic [SAMPLE_WIDTH-1:0]        dc;
  logic signed [SAMPLE_WIDTH:0]   ac_d, ac_q;
  logic                           s2v_q;

  // The estimate never leaves [0, 2^ACC_W) since dc_acc >= dc << DC_SHIFT, so no clamp is needed.
  always_comb begin
    dc      = SAMPLE_WIDTH'(dcAcc_q >> DC_SHIFT);
    ac_d    = $signed({1'b0, avg_i}) - $signed({1'b0, dc});
    dcAcc_d = dcAcc_q;
    if (s1v_i) begin
      dcAcc_d = dcAcc_q + ACC_W'(ac_d);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcAcc_q <= DC_RESET;
      ac_q    <= '0;
      s2v_q   <= 1'b0;
    end else begin
      dcAcc_q <= dcAcc_d;
      s2v_q   <= s1v_i;
      if (s1v_i) begin
        ac_q <= ac_d;
      end
    end
  end

  assign ac_o  = ac_q;
  assign s2v_o = s2v_q;

endmodule

// File: rtl/adc_sample_conditioner.sv
// Boxcar-decimates the raw ADC stream, removes DC, scales/saturates to OUT_W bits and
// hands offset-binary samples to the sdft through a one-entry valid/ready register.
module adc_sample_conditioner #(
  parameter int SAMPLE_WIDTH = waterfall_pkg::SAMPLE_WIDTH,
  parameter int OUT_W        = waterfall_pkg::DATA_W,
  parameter int DECIM_LOG2   = 2,
  parameter int DC_SHIFT     = 8,
  parameter int GAIN_SHIFT   = 1
) (
  input logic                     clk,
  input logic                     resetn,
  adc_sample_conditioner_if.slave bus
);

  localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [OUT_W-1:0] OUT_MID = OUT_W'(1) << (OUT_W - 1);
  localparam logic signed [SAMPLE_WIDTH:0] SAT_HI = (SAMPLE_WIDTH + 1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SAMPLE_WIDTH:0] SAT_LO = (SAMPLE_WIDTH + 1)'(-(1 << (OUT_W - 1)));

  logic [ACC_W-1:0]             acc_q, acc_d, sum;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0]      avg_q, avg_d;
  logic                         s1v_q, s1v_d;
  logic                         blockDone;
  logic signed [SAMPLE_WIDTH:0] ac;
  logic                         s2v;
  logic signed [SAMPLE_WIDTH:0] sc;
  logic signed [OUT_W-1:0]      sat;
  logic [OUT_W-1:0]             outSample_q, outSample_d;
  logic                         outValid_q, outValid_d;
  logic                         overrun_q, overrun_d;

  // The strobe that finds cnt at all-ones closes the block; its sample joins the average.
  always_comb begin
    sum       = acc_q + ACC_W'(bus.adc_data);
    blockDone = (DECIM_LOG2 == 0) ? 1'b1 : (cnt_q == '1);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    s1v_d     = 1'b0;
    if (bus.adc_valid) begin
      if (blockDone) begin
        acc_d = '0;
        cnt_d = '0;
        avg_d = SAMPLE_WIDTH'(sum >> DECIM_LOG2);
        s1v_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      s1v_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
      s1v_q <= s1v_d;
    end
  end

  dc_tracker #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .DC_SHIFT    (DC_SHIFT)
  ) u_dc_tracker (
    .clk   (clk),
    .resetn(resetn),
    .avg_i (avg_q),
    .s1v_i (s1v_q),
    .ac_o  (ac),
    .s2v_o (s2v)
  );

  // A transfer and a fresh load in the same cycle is a hand-over, not an overrun.
  always_comb begin
    sc = ac >>> GAIN_SHIFT;
    if (sc > SAT_HI) begin
      sat = OUT_W'(SAT_HI);
    end else if (sc < SAT_LO) begin
      sat = OUT_W'(SAT_LO);
    end else begin
      sat = OUT_W'(sc);
    end

    outSample_d = outSample_q;
    outValid_d  = outValid_q;
    overrun_d   = overrun_q;
    if (s2v) begin
      outSample_d = $unsigned(sat) + OUT_MID;
      outValid_d  = 1'b1;
      if (outValid_q && !bus.out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end
    if (bus.clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outSample_q <= OUT_MID;
      outValid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      outSample_q <= outSample_d;
      outValid_q  <= outValid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_sample = outSample_q;
  assign bus.out_valid  = outValid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/adc_sample_conditioner.md
# adc_sample_conditioner

Conditions raw microphone ADC samples before the sliding DFT. It boxcar-decimates the 12-bit ADC stream, removes the DC offset with a first-order tracker, scales and saturates to 8 bits, and presents offset-binary samples on a valid/ready handshake. It sits between the serial ADC and the sdft sample input, replacing the fixed `adc_data[8:1]` bit-slice, and runs in the pixel clock domain.

## Interface
- `SAMPLE_WIDTH`, 12: ADC sample width (unsigned).
- `OUT_W`, 8: output sample width; matches sdft `DATA_W`.
- `DECIM_LOG2`, 2: log2 of the decimation factor (factor 4); 0 means no decimation.
- `DC_SHIFT`, 8: DC tracker time constant, 2^DC_SHIFT output samples.
- `GAIN_SHIFT`, 1: arithmetic right shift applied to the AC value before saturation.

Ports:
- `clk`, in, 1: pixel clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `adc_data`, in, SAMPLE_WIDTH: unsigned ADC sample.
- `adc_valid`, in, 1: one-cycle strobe, one per new ADC conversion.
- `out_sample`, out, OUT_W: conditioned sample, offset binary (midscale = 2^(OUT_W-1)).
- `out_valid`, out, 1: `out_sample` holds an unconsumed sample.
- `out_ready`, in, 1: consumer accepts the sample this cycle.
- `overrun`, out, 1: sticky flag; an unconsumed sample was overwritten.
- `clear_overrun`, in, 1: synchronous clear of `overrun`.

## Operation
- **Decimate.** `acc` is SAMPLE_WIDTH+DECIM_LOG2 bits wide and `cnt` is DECIM_LOG2 bits wide.
  - On `adc_valid`, `acc` adds `adc_data` and `cnt` increments.
  - When `cnt` wraps to all-ones, `avg = (acc + adc_data) >> DECIM_LOG2`. `avg` is registered with strobe `s1_v`, and `acc` reloads to 0.
  - Samples arriving while `adc_valid` is low are ignored.
- **DC removal.** `dc_acc` is SAMPLE_WIDTH+DC_SHIFT bits wide and resets to `2^(SAMPLE_WIDTH-1) << DC_SHIFT`.
  - `dc = dc_acc >> DC_SHIFT`.
  - On `s1_v`:
    - `ac = avg - dc` is a signed SAMPLE_WIDTH+1-bit value and uses the pre-update `dc`.
    - `dc_acc` is updated to `dc_acc + avg - dc`.
  - The result is registered with strobe `s2_v`.
- **Scale and saturate.**
  - `sc = ac >>> GAIN_SHIFT`.
  - Clamp `sc` to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Add 2^(OUT_W-1) to convert to offset binary.
- **Output register (one entry).**
  - On `s2_v`, load `out_sample` and set `out_valid`.
  - On `out_valid && out_ready` with no `s2_v` in the same cycle, clear `out_valid`.
  - `s2_v && out_valid && !out_ready` overwrites `out_sample` and sets `overrun`.
  - `s2_v && out_valid && out_ready`: the old sample transfers, the new one loads, `out_valid` stays 1, and `overrun` is not set.
  - `clear_overrun` has priority over a same-cycle set.

## Timing
- Reset values:
  - `out_sample` = 2^(OUT_W-1) (128 at default).
  - `out_valid` = 0.
  - `overrun` = 0.
  - `acc`, `cnt`, `s1_v`, `s2_v` are all 0.
  - `dc_acc` is at midscale.
- Latency: the `adc_valid` that completes a decimation block at cycle n gives `out_valid` high at n+3 (stages s1, s2, out).
- Throughput is one input per cycle sustained; no back-pressure reaches the ADC side.
- `out_sample` is stable whenever `out_valid`=1, except on an overwrite.
- Reset asserted mid-block discards the partial accumulation and any pending output.
- The first output after reset uses `dc` = 2048 at default parameters.

## Structure
- Shared package `waterfall_pkg`: `SAMPLE_WIDTH`, `DATA_W` (= `OUT_W`), and the midscale constant. The same values are used by top, sdft and this block.
- One sub-module, `dc_tracker`: holds `dc_acc`, takes `avg` and `s1_v`, and outputs the registered `ac` and `s2_v`.
- Decimator, saturator and output register stay in the top level of this block.

## Test plan
- **Reset.** Hold `resetn` low, release.
  - Expect `out_sample`=128, `out_valid`=0, `overrun`=0.
- **Midscale DC.** Feed 8 strobes of `adc_data`=2048 with `out_ready`=1.
  - Expect exactly 2 outputs, both 128, each 3 cycles after the 4th/8th strobe.
- **Small offset.** Immediately after reset, feed 4 strobes of 2148.
  - Expect the first output to be 178 (ac=100, shifted to 50).
  - Continue feeding for 4096 samples; expect the output to converge to within ±1 of 128.
- **Saturation.** After reset, a block of 4095 gives 255 (1023 clamped to 127). After a fresh reset, a block of 0 gives 0 (-1024 clamped to -128).
- **Overrun.**
  - With `out_ready`=0, complete 2 blocks: expect `overrun`=1 and `out_sample` equal to the second result.
  - Pulse `clear_overrun`: expect `overrun`=0.
  - Assert `out_ready` for 1 cycle: expect `out_valid`=0.
- **Simultaneous events.**
  - Align `s2_v` with an `out_valid && out_ready` transfer: expect `out_valid` to stay 1, the new value to load, and `overrun` to stay 0.
  - Assert `resetn` low mid-block: expect no output until 4 fresh strobes have arrived.
